// File: rtl/port_arbiter_rr.sv
// port_arbiter_rr: round-robin, wormhole-locking arbiter for one router output.
// Inputs are ordered L (bit 2), N (bit 1), E (bit 0). A winning head flit locks
// the port to its input until that packet's tail (or single) flit transfers.
// Optional build macro: ARB_LOCK_TIMEOUT_EN adds a forced release of a lock
// whose owner has stopped requesting for TIMEOUT cycles.
module port_arbiter_rr #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [5:0] req_type,
  input  logic       out_full,
  output logic [2:0] arb_res,
  output logic       locked,
  output logic [2:0] owner,
  output logic [2:0] prio,
  output logic       timeout_pulse
);

  localparam int unsigned N_IN   = 3;
  localparam int unsigned TYPE_W = 2;

  localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b10;
  localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [N_IN-1:0] SEL_L    = 3'b100;
  localparam logic [N_IN-1:0] SEL_N    = 3'b010;
  localparam logic [N_IN-1:0] SEL_E    = 3'b001;
  localparam logic [N_IN-1:0] SEL_NONE = 3'b000;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [N_IN-1:0]   r_owner;
  logic [N_IN-1:0]   w_owner_nxt;
  logic [N_IN-1:0]   r_prio;
  logic [N_IN-1:0]   w_prio_nxt;
  logic              r_pulse;
  logic              w_pulse_nxt;

  logic [TYPE_W-1:0] w_type [N_IN];
  logic [N_IN-1:0]   w_elig;
  logic [N_IN-1:0]   w_pick;
  logic [N_IN-1:0]   w_grant;
  logic [TYPE_W-1:0] w_win_type;
  logic              w_xfer;
  logic              w_owner_req;
  logic              w_to_fire;
  logic [N_IN-1:0]   w_rot_grant;
  logic [N_IN-1:0]   w_rot_owner;

  // Split the packed type vector and flag inputs that may start a packet.
  always_comb begin
    for (int i = 0; i < int'(N_IN); i++) begin
      w_type[i] = req_type[TYPE_W*i +: TYPE_W];
      w_elig[i] = req[i] & ((w_type[i] == FLIT_HEAD) | (w_type[i] == FLIT_SINGLE));
    end
  end

  // First eligible input in the order selected by the round-robin pointer.
  always_comb begin
    w_pick = SEL_NONE;
    case (r_prio)
      SEL_N: begin
        if      (w_elig[1]) w_pick = SEL_N;
        else if (w_elig[0]) w_pick = SEL_E;
        else if (w_elig[2]) w_pick = SEL_L;
      end
      SEL_E: begin
        if      (w_elig[0]) w_pick = SEL_E;
        else if (w_elig[2]) w_pick = SEL_L;
        else if (w_elig[1]) w_pick = SEL_N;
      end
      default: begin
        if      (w_elig[2]) w_pick = SEL_L;
        else if (w_elig[1]) w_pick = SEL_N;
        else if (w_elig[0]) w_pick = SEL_E;
      end
    endcase
  end

  assign w_owner_req = |(r_owner & req);
  assign w_grant     = (r_state == ST_LOCKED) ? (r_owner & req) : w_pick;
  assign w_xfer      = (|w_grant) & ~out_full;

  // Flit type of the current winner; only meaningful when w_xfer is set.
  always_comb begin
    w_win_type = FLIT_BODY;
    case (w_grant)
      SEL_L:   w_win_type = w_type[2];
      SEL_N:   w_win_type = w_type[1];
      SEL_E:   w_win_type = w_type[0];
      default: w_win_type = FLIT_BODY;
    endcase
  end

  // Completion by input i hands priority to the next lower index, wrapping E->L.
  assign w_rot_grant = {w_grant[0], w_grant[N_IN-1:1]};
  assign w_rot_owner = {r_owner[0], r_owner[N_IN-1:1]};

`ifdef ARB_LOCK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [TIMEOUT_W-1:0] w_to_cnt_nxt;

  assign w_to_fire = (r_state == ST_LOCKED) & ~w_owner_req &
                     (r_to_cnt == TIMEOUT_W'(TIMEOUT - 1));

  // Idle-owner counter: counts locked cycles with no owner request.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (w_xfer || (w_state_nxt == ST_IDLE)) begin
      w_to_cnt_nxt = '0;
    end else if ((r_state == ST_LOCKED) && !w_owner_req) begin
      w_to_cnt_nxt = r_to_cnt + TIMEOUT_W'(1);
    end
  end

  // Idle-owner counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`else
  logic [TIMEOUT_W-1:0] w_unused_cfg;
  logic                 w_unused_req;

  assign w_to_fire    = 1'b0;
  assign w_unused_cfg = TIMEOUT_W'(TIMEOUT);
  assign w_unused_req = w_owner_req;
`endif

  // Next-state, next-owner and pointer update for the lock FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_win_type == FLIT_HEAD) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_grant;
          end else begin
            w_prio_nxt = w_rot_grant;
          end
        end
      end
      ST_LOCKED: begin
        if (w_xfer) begin
          if ((w_win_type == FLIT_TAIL) || (w_win_type == FLIT_SINGLE)) begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = SEL_NONE;
            w_prio_nxt  = w_rot_grant;
          end
        end else if (w_to_fire) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = SEL_NONE;
          w_prio_nxt  = w_rot_owner;
          w_pulse_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = SEL_NONE;
      end
    endcase
  end

  // State, owner, pointer and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= SEL_NONE;
      r_prio  <= SEL_L;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign arb_res       = rst_n ? w_grant : SEL_NONE;
  assign locked        = (r_state == ST_LOCKED);
  assign owner         = r_owner;
  assign prio          = r_prio;
  assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_port_arbiter_rr.sv
// Directed bench for port_arbiter_rr. Builds with or without ARB_LOCK_TIMEOUT_EN
// (DUT TIMEOUT overridden to 4).
module tb_port_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [5:0] req_type;
  logic       out_full;
  logic [2:0] arb_res;
  logic       locked;
  logic [2:0] owner;
  logic [2:0] prio;
  logic       timeout_pulse;

  int unsigned n_vec;
  int unsigned n_err;
  logic [7:0]  exp_st;
  logic [2:0]  exp_arb;
  logic [7:0]  st;

  // st = {locked, owner, prio, timeout_pulse}
  assign st = {locked, owner, prio, timeout_pulse};

  port_arbiter_rr #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_type(req_type),
    .out_full(out_full), .arb_res(arb_res), .locked(locked),
    .owner(owner), .prio(prio), .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; req_type = 6'b111111; out_full = 1'b0;
    #12;
    exp_arb = 3'b000; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL reset_arb got=%b exp=%b", arb_res, exp_arb); end
    exp_st = {1'b0, 3'b000, 3'b100, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL reset_state got=%b exp=%b", st, exp_st); end
    rst_n = 1'b1;
  endtask

  task automatic test_rr_single();
    logic [2:0] arb_tbl [3];
    logic [2:0] prio_tbl [3];
    arb_tbl  = '{3'b100, 3'b010, 3'b001};
    prio_tbl = '{3'b010, 3'b001, 3'b100};
    req = 3'b111; req_type = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (arb_res !== arb_tbl[i]) begin n_err++; $display("FAIL rr_arb%0d got=%b exp=%b", i, arb_res, arb_tbl[i]); end
      step();
      exp_st = {1'b0, 3'b000, prio_tbl[i], 1'b0}; n_vec++;
      if (st !== exp_st) begin n_err++; $display("FAIL rr_state%0d got=%b exp=%b", i, st, exp_st); end
    end
  endtask

  task automatic test_wormhole();
    // Move pointer to E: L single then N single.
    req = 3'b100; req_type = 6'b110000; #1;
    exp_arb = 3'b100; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL wh_pre_l got=%b exp=%b", arb_res, exp_arb); end
    step();
    req = 3'b010; req_type = 6'b001100; step();
    exp_st = {1'b0, 3'b000, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL wh_pre_prio got=%b exp=%b", st, exp_st); end
    // E head while L also offers a head.
    req = 3'b101; req_type = 6'b000000; #1;
    exp_arb = 3'b001; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL wh_head got=%b exp=%b", arb_res, exp_arb); end
    step();
    exp_st = {1'b1, 3'b001, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL wh_locked got=%b exp=%b", st, exp_st); end
    req_type = 6'b000001; #1;
    n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL wh_body got=%b exp=%b", arb_res, exp_arb); end
    step();
    n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL wh_body_state got=%b exp=%b", st, exp_st); end
    req_type = 6'b000010; #1;
    n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL wh_tail got=%b exp=%b", arb_res, exp_arb); end
    step();
    exp_st = {1'b0, 3'b000, 3'b100, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL wh_unlock got=%b exp=%b", st, exp_st); end
    // L now wins and runs its own head/tail.
    req = 3'b100; req_type = 6'b000000; #1;
    exp_arb = 3'b100; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL wh_l_wins got=%b exp=%b", arb_res, exp_arb); end
    step();
    req_type = 6'b100000; step();
    exp_st = {1'b0, 3'b000, 3'b010, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL wh_l_done got=%b exp=%b", st, exp_st); end
  endtask

  task automatic test_full_stall();
    req = 3'b010; req_type = 6'b000000; step();
    exp_st = {1'b1, 3'b010, 3'b010, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL full_lock got=%b exp=%b", st, exp_st); end
    out_full = 1'b1; req_type = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_arb = 3'b010; n_vec++;
      if (arb_res !== exp_arb) begin n_err++; $display("FAIL full_arb%0d got=%b exp=%b", i, arb_res, exp_arb); end
      step();
      n_vec++;
      if (st !== exp_st) begin n_err++; $display("FAIL full_state%0d got=%b exp=%b", i, st, exp_st); end
    end
    out_full = 1'b0; req_type = 6'b001000; step();
    exp_st = {1'b0, 3'b000, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL full_resume got=%b exp=%b", st, exp_st); end
  endtask

  task automatic test_ignore_body();
    req = 3'b010; req_type = 6'b000100; #1;
    exp_arb = 3'b000; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL idle_body got=%b exp=%b", arb_res, exp_arb); end
    step();
    exp_st = {1'b0, 3'b000, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL idle_body_state got=%b exp=%b", st, exp_st); end
    req = 3'b001; req_type = 6'b000010; #1;
    n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL idle_tail got=%b exp=%b", arb_res, exp_arb); end
    req = 3'b111; req_type = 6'b011000; #1;
    exp_arb = 3'b001; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL idle_mixed got=%b exp=%b", arb_res, exp_arb); end
  endtask

  task automatic test_multi_hot();
    req = 3'b111; req_type = 6'b000000; #1;
    exp_arb = 3'b001; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL multi_all got=%b exp=%b", arb_res, exp_arb); end
    req = 3'b110; #1;
    exp_arb = 3'b100; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL multi_wrap got=%b exp=%b", arb_res, exp_arb); end
    out_full = 1'b1; req = 3'b010; req_type = 6'b001100; #1;
    exp_arb = 3'b010; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL full_idle_arb got=%b exp=%b", arb_res, exp_arb); end
    step();
    exp_st = {1'b0, 3'b000, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL full_idle_state got=%b exp=%b", st, exp_st); end
    out_full = 1'b0;
  endtask

  task automatic test_timeout();
    req = 3'b100; req_type = 6'b000000; step();
    exp_st = {1'b1, 3'b100, 3'b001, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL to_lock got=%b exp=%b", st, exp_st); end
    req = 3'b000; #1;
    exp_arb = 3'b000; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL to_arb got=%b exp=%b", arb_res, exp_arb); end
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (st !== exp_st) begin n_err++; $display("FAIL to_wait%0d got=%b exp=%b", i, st, exp_st); end
    end
    step();
    exp_st = {1'b0, 3'b000, 3'b010, 1'b1}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL to_fire got=%b exp=%b", st, exp_st); end
    step();
    exp_st = {1'b0, 3'b000, 3'b010, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL to_pulse_end got=%b exp=%b", st, exp_st); end
`else
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (st !== exp_st) begin n_err++; $display("FAIL hold%0d got=%b exp=%b", i, st, exp_st); end
    end
    req = 3'b100; req_type = 6'b100000; step();
    exp_st = {1'b0, 3'b000, 3'b010, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL hold_release got=%b exp=%b", st, exp_st); end
`endif
  endtask

  task automatic test_reset_mid();
    req = 3'b010; req_type = 6'b000000; step();
    exp_st = {1'b1, 3'b010, 3'b010, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL rm_lock got=%b exp=%b", st, exp_st); end
    req_type = 6'b000100;
    #2 rst_n = 1'b0;
    #1;
    exp_arb = 3'b000; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL rm_arb got=%b exp=%b", arb_res, exp_arb); end
    exp_st = {1'b0, 3'b000, 3'b100, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL rm_state got=%b exp=%b", st, exp_st); end
    #2 rst_n = 1'b1;
    req = 3'b001; req_type = 6'b000000; #1;
    exp_arb = 3'b001; n_vec++;
    if (arb_res !== exp_arb) begin n_err++; $display("FAIL rm_fresh got=%b exp=%b", arb_res, exp_arb); end
    step();
    exp_st = {1'b1, 3'b001, 3'b100, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL rm_relock got=%b exp=%b", st, exp_st); end
    req_type = 6'b000010; step();
    exp_st = {1'b0, 3'b000, 3'b100, 1'b0}; n_vec++;
    if (st !== exp_st) begin n_err++; $display("FAIL rm_done got=%b exp=%b", st, exp_st); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rr_single();
    test_wormhole();
    test_full_stall();
    test_ignore_body();
    test_multi_hot();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
